// File: rtl/adder_share_arbiter.sv
// Round-robin share of one 8-bit adder between two valid/ready requesters.
// Optional grant statistics counters: define ADDER_ARB_STATS_EN.

module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

module adder_share_arbiter #(
    parameter bit START_PRIO = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid0,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_b0,
    output logic       req_ready0,
    input  logic       req_valid1,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b1,
    output logic       req_ready1,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_sum,
    output logic       resp_carry,
    output logic       resp_id,
    output logic       busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t     state;
    logic       prio;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_id;
    logic [7:0] sum;
    logic       carry;
    logic       grant0;
    logic       grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case (1'b1)
            (req_valid0 && req_valid1): begin
                grant0 = !prio;
                grant1 = prio;
            end
            (req_valid0 && !req_valid1): grant0 = 1'b1;
            (!req_valid0 && req_valid1): grant1 = 1'b1;
            default: ;
        endcase
    end

    assign req_ready0 = (state == IDLE) && grant0;
    assign req_ready1 = (state == IDLE) && grant1;
    assign busy       = (state != IDLE);

    adder_8bit u_add (op_a, op_b, sum, carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= START_PRIO;
            op_a       <= 8'd0;
            op_b       <= 8'd0;
            op_id      <= 1'b0;
            resp_valid <= 1'b0;
            resp_sum   <= 8'd0;
            resp_carry <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready0 || req_ready1) begin
                        op_a  <= req_ready1 ? req_a1 : req_a0;
                        op_b  <= req_ready1 ? req_b1 : req_b0;
                        op_id <= req_ready1;
                        // Winner loses priority to the other side.
                        prio  <= !req_ready1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    resp_sum   <= sum;
                    resp_carry <= carry;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (req_ready0 && (gnt_cnt0 != '1))
                gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (req_ready1 && (gnt_cnt1 != '1))
                gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
